// File: rtl/instr_sequencer_pkg.sv
// Shared state codes and opcodes for the instruction sequencer and its users.
// Opcode lives in instruction word bits [31:24].
package instr_sequencer_pkg;

   typedef enum logic [3:0] {
      ST_HALT   = 4'd0,
      ST_FETCH0 = 4'd1,
      ST_FETCH1 = 4'd2,
      ST_EXEC   = 4'd3,
      ST_HOLD   = 4'd4
   } state_t;

   localparam logic [7:0] OP_NOP    = 8'h00;
   localparam logic [7:0] OP_LIMM16 = 8'h01;
   localparam logic [7:0] OP_LIMM32 = 8'h02;
   localparam logic [7:0] OP_LBSET  = 8'h03;
   localparam logic [7:0] OP_CND    = 8'h04;
   localparam logic [7:0] OP_END    = 8'h05;

   function automatic logic [7:0] opcode_of(input logic [31:0] i_word);
      return i_word[31:24];
   endfunction

endpackage

// File: rtl/instr_sequencer_op_len_decode.sv
// Instruction length decode: flags opcodes that carry a second 32-bit word.
module op_len_decode
   import instr_sequencer_pkg::*;
(
   input  logic [7:0] i_opcode,
   output logic       o_is_two_word
);

   always_comb begin
      o_is_two_word = (i_opcode == OP_LIMM32) || (i_opcode == OP_LBSET);
   end

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/issue controller: fetches one- or two-word instructions and issues a single EXEC cycle.
// Optional SEQ_STEP_EN adds a step input that gates every non-skipped EXEC.
module instr_sequencer
   import instr_sequencer_pkg::*;
#(
   parameter int PC_W     = 16,
   parameter int RESET_PC = 0
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
`ifdef SEQ_STEP_EN
   input  logic            step,
`endif
   output logic            imem_req,
   output logic [PC_W-1:0] imem_addr,
   input  logic            imem_ack,
   input  logic [31:0]     imem_data,
   input  logic            cnd_true,
   output logic [31:0]     instr0,
   output logic [31:0]     instr1,
   output logic [3:0]      current_state,
   output logic            halted,
   output logic [PC_W-1:0] pc
);

   localparam logic [PC_W-1:0] C_RESET_PC = PC_W'(RESET_PC);
`ifdef SEQ_STEP_EN
   localparam state_t C_DONE = ST_HOLD;
`else
   localparam state_t C_DONE = ST_EXEC;
`endif

   state_t          r_state;
   state_t          w_next;
   logic [PC_W-1:0] r_pc;
   logic [31:0]     r_instr0;
   logic [31:0]     r_instr1;
   logic            r_skip;
   logic            r_gap;
   logic            w_req;
   logic            w_accept;
   logic            w_two_word;
   logic            w_last_word;
   logic            w_step;
   logic [7:0]      w_exec_op;

   op_len_decode u_op_len_decode (
      .i_opcode      (opcode_of(imem_data)),
      .o_is_two_word (w_two_word)
   );

`ifdef SEQ_STEP_EN
   assign w_step = step;
`else
   assign w_step = 1'b1;
`endif

   // r_gap forces one idle cycle after every accepted word, so requests are never back-to-back.
   assign w_req       = ((r_state == ST_FETCH0) || (r_state == ST_FETCH1)) && !r_gap;
   assign w_accept    = w_req && imem_ack;
   assign w_last_word = w_accept && !((r_state == ST_FETCH0) && w_two_word);
   assign w_exec_op   = opcode_of(r_instr0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_HALT;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_HALT: begin
            if (start) w_next = ST_FETCH0;
         end
         ST_FETCH0: begin
            if (w_accept) begin
               if (w_two_word) w_next = ST_FETCH1;
               else if (r_skip) w_next = ST_FETCH0;
               else w_next = C_DONE;
            end
         end
         ST_FETCH1: begin
            if (w_accept) w_next = r_skip ? ST_FETCH0 : C_DONE;
         end
         ST_HOLD: begin
            if (w_step) w_next = ST_EXEC;
         end
         ST_EXEC: begin
            w_next = (w_exec_op == OP_END) ? ST_HALT : ST_FETCH0;
         end
         default: w_next = ST_HALT;
      endcase
   end

   always_comb begin
      imem_req      = w_req;
      imem_addr     = w_req ? r_pc : '0;
      instr0        = r_instr0;
      instr1        = r_instr1;
      current_state = r_state;
      halted        = (r_state == ST_HALT);
      pc            = r_pc;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pc     <= C_RESET_PC;
         r_instr0 <= '0;
         r_instr1 <= '0;
         r_skip   <= 1'b0;
         r_gap    <= 1'b0;
      end else begin
         r_gap <= w_accept;
         if ((r_state == ST_HALT) && start) begin
            r_pc <= C_RESET_PC;
         end else if (w_accept) begin
            r_pc <= r_pc + 1'b1;
         end
         if (w_accept && (r_state == ST_FETCH0)) begin
            r_instr0 <= imem_data;
            r_instr1 <= '0;
         end else if (w_accept) begin
            r_instr1 <= imem_data;
         end
         // The skip flag is consumed by the next complete fetch, so a skipped CND cannot chain.
         if (w_last_word && r_skip) begin
            r_skip <= 1'b0;
         end else if ((r_state == ST_EXEC) && (w_exec_op == OP_CND) && !cnd_true) begin
            r_skip <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: instruction-level program model feeds expected fetch/EXEC queues.
// Build with +define+SEQ_STEP_EN to include the step-gating scenario.
module tb_instr_sequencer;
   import instr_sequencer_pkg::*;

   localparam int PC_W  = 4;
   localparam int RPC   = 14;
   localparam int MEM_N = 16;

   logic            clk;
   logic            reset;
   logic            start;
`ifdef SEQ_STEP_EN
   logic            step;
`endif
   logic            imem_req;
   logic [PC_W-1:0] imem_addr;
   logic            imem_ack;
   logic [31:0]     imem_data;
   logic            cnd_true;
   logic [31:0]     instr0;
   logic [31:0]     instr1;
   logic [3:0]      current_state;
   logic            halted;
   logic [PC_W-1:0] pc;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int start_cyc = 0;
   int lat      = 1;
   int fetch_rises = 0;

   logic [31:0] mem [MEM_N];
   logic [31:0] exp_fetch[$];
   logic [31:0] exp_i0[$];
   logic [31:0] exp_i1[$];
   logic [31:0] exp_pc[$];
   logic [31:0] log_i0[$];
   logic [31:0] log_i1[$];
   logic [31:0] log_pc[$];
   int          log_cyc[$];

   instr_sequencer #(.PC_W(PC_W), .RESET_PC(RPC)) dut (
      .clk           (clk),
      .reset         (reset),
      .start         (start),
`ifdef SEQ_STEP_EN
      .step          (step),
`endif
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_ack      (imem_ack),
      .imem_data     (imem_data),
      .cnd_true      (cnd_true),
      .instr0        (instr0),
      .instr1        (instr1),
      .current_state (current_state),
      .halted        (halted),
      .pc            (pc)
   );

   // clock / watchdog
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic note_fail(input string name, input logic [31:0] act);
      checks++;
      failures++;
      $display("FAIL %s actual=%h required=none", name, act);
   endtask

   // Memory responder: latches each request, answers after lat cycles with a one-cycle ack.
   initial begin
      bit          pending;
      int          cnt;
      logic [31:0] pdata;
      imem_ack  = 1'b0;
      imem_data = '0;
      pending   = 1'b0;
      cnt       = 0;
      pdata     = '0;
      forever begin
         @(negedge clk);
         if (imem_ack) begin
            imem_ack = 1'b0;
         end else if (pending) begin
            cnt--;
            if (cnt <= 0) begin
               imem_ack  = 1'b1;
               imem_data = pdata;
               pending   = 1'b0;
            end
         end else if (imem_req) begin
            pending = 1'b1;
            pdata   = mem[imem_addr];
            cnt     = lat;
         end
      end
   end

   // Compare process: every EXEC cycle and every new request is checked against the model.
   initial begin
      logic            prev_req;
      logic [PC_W-1:0] prev_addr;
      prev_req  = 1'b0;
      prev_addr = '0;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         if (!reset) begin
            if (current_state == ST_EXEC) begin
               if (exp_i0.size() == 0) begin
                  note_fail("exec_unexpected", instr0);
               end else begin
                  chk("exec_instr0", instr0, exp_i0.pop_front());
                  chk("exec_instr1", instr1, exp_i1.pop_front());
                  chk("exec_pc", 32'(pc), exp_pc.pop_front());
               end
               log_i0.push_back(instr0);
               log_i1.push_back(instr1);
               log_pc.push_back(32'(pc));
               log_cyc.push_back(cyc);
            end
            if (imem_req && !prev_req) begin
               fetch_rises++;
               if (exp_fetch.size() == 0) note_fail("fetch_unexpected", 32'(imem_addr));
               else chk("fetch_addr", 32'(imem_addr), exp_fetch.pop_front());
            end
            if (imem_req && prev_req && (imem_addr != prev_addr)) begin
               note_fail("req_not_released", 32'(imem_addr));
            end
         end
         prev_req  = imem_req;
         prev_addr = imem_addr;
      end
   end

   // Program model: walks the program word by word applying the CND/END/skip rules.
   task automatic build_expect(input bit cnd);
      int          p;
      bit          skip;
      logic [31:0] w0;
      logic [31:0] w1;
      logic [7:0]  op;
      p    = RPC;
      skip = 1'b0;
      for (int n = 0; n < 32; n++) begin
         w0 = mem[p];
         op = w0[31:24];
         exp_fetch.push_back(32'(p));
         p  = (p + 1) % MEM_N;
         w1 = '0;
         if (op == OP_LIMM32 || op == OP_LBSET) begin
            exp_fetch.push_back(32'(p));
            w1 = mem[p];
            p  = (p + 1) % MEM_N;
         end
         if (skip) begin
            skip = 1'b0;
            continue;
         end
         exp_i0.push_back(w0);
         exp_i1.push_back(w1);
         exp_pc.push_back(32'(p));
         if (op == OP_END) break;
         if (op == OP_CND && !cnd) skip = 1'b1;
      end
   endtask

   // driver tasks
   task automatic clear_all();
      exp_fetch.delete(); exp_i0.delete(); exp_i1.delete(); exp_pc.delete();
      log_i0.delete(); log_i1.delete(); log_pc.delete(); log_cyc.delete();
      fetch_rises = 0;
      for (int i = 0; i < MEM_N; i++) mem[i] = '0;
   endtask

   task automatic do_start();
      @(negedge clk);
      start     = 1'b1;
      start_cyc = cyc;
      @(negedge clk);
      start     = 1'b0;
   endtask

   task automatic wait_halt();
      int n;
      n = 0;
      while (!halted && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (!halted) note_fail("halt_timeout", 32'(current_state));
      repeat (6) @(negedge clk);
      chk("fetch_left", 32'(exp_fetch.size()), 32'd0);
      chk("exec_left", 32'(exp_i0.size()), 32'd0);
      chk("halted_end", 32'(halted), 32'd1);
   endtask

   task automatic run_prog(input int lat_in, input bit cnd);
      lat      = lat_in;
      cnd_true = cnd;
      build_expect(cnd);
      do_start();
      wait_halt();
   endtask

   initial begin
      reset    = 1'b1;
      start    = 1'b0;
      cnd_true = 1'b0;
`ifdef SEQ_STEP_EN
      step     = 1'b1;
`endif
      clear_all();
      repeat (3) @(negedge clk);
      chk("rst_state", 32'(current_state), 32'(ST_HALT));
      chk("rst_halted", 32'(halted), 32'd1);
      chk("rst_req", 32'(imem_req), 32'd0);
      chk("rst_addr", 32'(imem_addr), 32'd0);
      chk("rst_instr0", instr0, 32'd0);
      chk("rst_instr1", instr1, 32'd0);
      chk("rst_pc", 32'(pc), 32'd14);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      // one-word op, 3-cycle latency: EXEC five cycles after start
      clear_all();
      mem[14] = 32'h0100_1234;
      mem[15] = 32'h0500_0000;
      run_prog(3, 1'b0);
      chk("t1_latency", 32'(log_cyc[0] - start_cyc), 32'd5);
      chk("t1_instr0", log_i0[0], 32'h0100_1234);
      chk("t1_pc", log_pc[0], 32'd15);

      // two-word op straddling the pc wrap
      clear_all();
      mem[14] = 32'h0200_0000;
      mem[15] = 32'hDEAD_BEEF;
      mem[0]  = 32'h0500_0000;
      run_prog(2, 1'b0);
      chk("t2_latency", 32'(log_cyc[0] - start_cyc), 32'd8);
      chk("t2_instr1", log_i1[0], 32'hDEAD_BEEF);
      chk("t2_pc_wrap", log_pc[0], 32'd0);
      chk("t2_execs", 32'(log_i0.size()), 32'd2);

      // false CND skips a full two-word op
      clear_all();
      mem[14] = 32'h0400_0000;
      mem[15] = 32'h0200_0001;
      mem[0]  = 32'h1111_2222;
      mem[1]  = 32'h0100_0055;
      mem[2]  = 32'h0500_0000;
      run_prog(1, 1'b0);
      chk("t3_execs", 32'(log_i0.size()), 32'd3);
      chk("t3_after_skip", log_i0[1], 32'h0100_0055);
      chk("t3_after_skip_pc", log_pc[1], 32'd2);

      // true CND then END: halt, nothing fetched past END
      clear_all();
      mem[14] = 32'h0400_0000;
      mem[15] = 32'h0500_0000;
      mem[0]  = 32'h0100_00AA;
      run_prog(2, 1'b1);
      chk("t4_execs", 32'(log_i0.size()), 32'd2);
      chk("t4_end", log_i0[1], 32'h0500_0000);
      chk("t4_fetches", 32'(fetch_rises), 32'd2);

      // skipped END does not halt; unknown opcode still issues EXEC
      clear_all();
      mem[14] = 32'h0400_0000;
      mem[15] = 32'h0500_0000;
      mem[0]  = 32'hFF00_0000;
      mem[1]  = 32'h0500_0000;
      run_prog(1, 1'b0);
      chk("t4b_execs", 32'(log_i0.size()), 32'd3);
      chk("t4b_unknown", log_i0[1], 32'hFF00_0000);

      // reset during an outstanding fetch; the late ack must be ignored
      clear_all();
      mem[14] = 32'h0100_0077;
      exp_fetch.push_back(32'd14);
      lat      = 4;
      cnd_true = 1'b0;
      do_start();
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("t5_async_req", 32'(imem_req), 32'd0);
      chk("t5_async_state", 32'(current_state), 32'(ST_HALT));
      @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      chk("t5_state", 32'(current_state), 32'(ST_HALT));
      chk("t5_instr0", instr0, 32'd0);
      chk("t5_halted", 32'(halted), 32'd1);
      chk("t5_req", 32'(imem_req), 32'd0);
      chk("t5_pc", 32'(pc), 32'd14);
      chk("t5_fetch_left", 32'(exp_fetch.size()), 32'd0);

`ifdef SEQ_STEP_EN
      // step held low keeps the fetched op waiting; one pulse issues one EXEC
      begin
         int n;
         clear_all();
         mem[14] = 32'h0100_0099;
         mem[15] = 32'h0500_0000;
         lat      = 1;
         cnd_true = 1'b0;
         step     = 1'b0;
         build_expect(1'b0);
         do_start();
         n = 0;
         while (current_state != ST_HOLD && n < 50) begin
            @(negedge clk);
            n++;
         end
         repeat (10) @(negedge clk);
         chk("t6_hold_state", 32'(current_state), 32'(ST_HOLD));
         chk("t6_hold_halted", 32'(halted), 32'd0);
         chk("t6_no_exec", 32'(log_i0.size()), 32'd0);
         step = 1'b1;
         @(negedge clk);
         step = 1'b0;
         repeat (4) @(negedge clk);
         chk("t6_one_exec", 32'(log_i0.size()), 32'd1);
         step = 1'b1;
         wait_halt();
         chk("t6_execs", 32'(log_i0.size()), 32'd2);
      end
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
